optmult_rr_sched: RTL and testbench

//   Shares one combinational optmult_unclocked multiplier between NREQ requesters.

---
 rtl/optmult_rr_sched.sv | 141 ++++++++++++++
 tb/tb_optmult_rr_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/optmult_rr_sched.sv
// Round-robin scheduler sharing one external combinational/pipelined multiplier among NREQ requesters.
// Optional statistics counters are built when OPTMULT_SCHED_STATS_EN is defined.
module optmult_rr_sched #(
    parameter int NREQ     = 4,
    parameter int M_W      = 8,
    parameter int N_W      = 8,
    parameter int UNSIGNED = 1,
    parameter int MUL_LAT  = 0,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*M_W-1:0]   req_a,
    input  logic [NREQ*N_W-1:0]   req_b,
    output logic [M_W-1:0]        mul_a,
    output logic [N_W-1:0]        mul_b,
    input  logic [M_W+N_W-1:0]    mul_p,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [M_W+N_W-1:0]    resp_p,
`ifdef OPTMULT_SCHED_STATS_EN
    output logic [31:0]           stat_ops,
    output logic [31:0]           stat_wait,
`endif
    output logic                  busy
);

    localparam int CW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t               state_q;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        cnt_q;
    logic [M_W-1:0]       mul_a_q;
    logic [N_W-1:0]       mul_b_q;
    logic                 resp_valid_q;
    logic [IDW-1:0]       resp_id_q;
    logic [M_W+N_W-1:0]   resp_p_q;

    logic                 found;
    logic [IDW-1:0]       win;
    logic [NREQ-1:0]      gnt;
    logic [M_W-1:0]       a_sel;
    logic [N_W-1:0]       b_sel;

    // Pass 0 scans indices >= rr_ptr, pass 1 wraps to indices below it.
    always_comb begin
        found = 1'b0;
        win   = '0;
        gnt   = '0;
        a_sel = '0;
        b_sel = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && ((p == 0) == (i >= 32'(rr_ptr_q)))) begin
                    found  = 1'b1;
                    win    = IDW'(i);
                    gnt[i] = 1'b1;
                    a_sel  = req_a[i*M_W +: M_W];
                    b_sel  = req_b[i*N_W +: N_W];
                end
            end
        end
    end

    assign rr_ptr_d  = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign req_ready = (state_q == S_IDLE) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_p_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        mul_a_q   <= a_sel;
                        mul_b_q   <= b_sel;
                        resp_id_q <= win;
                        rr_ptr_q  <= rr_ptr_d;
                        cnt_q     <= '0;
                        state_q   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == CW'(MUL_LAT)) begin
                        resp_p_q     <= mul_p;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef OPTMULT_SCHED_STATS_EN
    logic [31:0] stat_ops_q, stat_wait_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q  <= '0;
            stat_wait_q <= '0;
        end else begin
            if (resp_valid_q && resp_ready && stat_ops_q != '1)
                stat_ops_q <= stat_ops_q + 32'd1;
            if ((|req_valid) && (req_ready == '0) && stat_wait_q != '1)
                stat_wait_q <= stat_wait_q + 32'd1;
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_wait = stat_wait_q;
`endif

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_p     = resp_p_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_optmult_rr_sched.sv
// Bench for optmult_rr_sched: directed table, multi-cycle sequences and a randomized run against a transaction model.
// Two instances: u0 with MUL_LAT=0, u2 with MUL_LAT=2 driving a two-stage multiplier model.
module tb_optmult_rr_sched;
    localparam int LAT0 = 0;
    localparam int LAT2 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_p, resp_p;
    logic        resp_valid, resp_ready, busy;
    logic [1:0]  resp_id;

    logic [3:0]  v2, rdy2;
    logic [31:0] a2, b2;
    logic [7:0]  ma2, mb2;
    logic [15:0] mp2, rp2, pipe1, pipe2;
    logic        rv2, rr2, busy2;
    logic [1:0]  rid2;
`ifdef OPTMULT_SCHED_STATS_EN
    logic [31:0] stat_ops, stat_wait, stat_ops2, stat_wait2;
`endif

    assign mul_p = 16'(mul_a) * 16'(mul_b);
    always_ff @(posedge clk) begin
        pipe1 <= 16'(ma2) * 16'(mb2);
        pipe2 <= pipe1;
    end
    assign mp2 = pipe2;

    optmult_rr_sched #(.NREQ(4), .M_W(8), .N_W(8), .UNSIGNED(1), .MUL_LAT(LAT0)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_p(resp_p),
`ifdef OPTMULT_SCHED_STATS_EN
        .stat_ops(stat_ops), .stat_wait(stat_wait),
`endif
        .busy(busy));

    optmult_rr_sched #(.NREQ(4), .M_W(8), .N_W(8), .UNSIGNED(1), .MUL_LAT(LAT2)) u2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2), .mul_a(ma2), .mul_b(mb2), .mul_p(mp2),
        .resp_valid(rv2), .resp_ready(rr2), .resp_id(rid2), .resp_p(rp2),
`ifdef OPTMULT_SCHED_STATS_EN
        .stat_ops(stat_ops2), .stat_wait(stat_wait2),
`endif
        .busy(busy2));

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        v2 = '0; a2 = '0; b2 = '0; rr2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [7:0]  a;
        logic [7:0]  b;
        int unsigned id;
        logic [15:0] p;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // operand of requester i is a + 16*i (mod 256), b is shared
        tbl[0] = '{4'b0001, 8'd13,  8'd11,  0, 16'd143};
        tbl[1] = '{4'b1111, 8'd10,  8'd3,   1, 16'd78};
        tbl[2] = '{4'b0011, 8'd5,   8'd7,   0, 16'd35};
        tbl[3] = '{4'b1000, 8'd1,   8'd200, 3, 16'd9800};
        tbl[4] = '{4'b0101, 8'd2,   8'd9,   0, 16'd18};
        tbl[5] = '{4'b0101, 8'd2,   8'd9,   2, 16'd306};
        tbl[6] = '{4'b0101, 8'd4,   8'd4,   0, 16'd16};
        tbl[7] = '{4'b0101, 8'd4,   8'd4,   2, 16'd144};
        tbl[8] = '{4'b1111, 8'd255, 8'd255, 3, 16'd11985};
        tbl[9] = '{4'b0010, 8'd255, 8'd1,   1, 16'd15};

        do_reset();
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 0);
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_resp_id", 64'(resp_id), 0);
        chk("rst_resp_p", 64'(resp_p), 0);
        chk("rst_mul_a", 64'(mul_a), 0);
        chk("rst_mul_b", 64'(mul_b), 0);
        chk("rst_busy", 64'(busy), 0);
        @(posedge clk); #1;

        foreach (tbl[k]) begin
            req_valid = tbl[k].v;
            resp_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                req_a[i*8 +: 8] = tbl[k].a + 8'(i * 16);
                req_b[i*8 +: 8] = tbl[k].b;
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", k), 64'(req_ready), 64'(4'(1) << tbl[k].id));
            @(posedge clk); #1 req_valid = '0;
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", k), 64'(busy), 1);
            chk($sformatf("tbl%0d_early_valid", k), 64'(resp_valid), 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", k), 64'(resp_valid), 1);
            chk($sformatf("tbl%0d_id", k), 64'(resp_id), 64'(tbl[k].id));
            chk($sformatf("tbl%0d_p", k), 64'(resp_p), 64'(tbl[k].p));
            @(posedge clk); #1;
        end

        // all requesters held: grants 0,1,2,3,0 spaced MUL_LAT+3 cycles
        begin
            int ngr = 0;
            int last = 0;
            do_reset();
            req_valid = 4'b1111; resp_ready = 1'b1; req_a = 32'h04030201; req_b = 32'h05050505;
            for (int cyc = 0; cyc < 40 && ngr < 5; cyc++) begin
                @(negedge clk);
                if (|req_ready) begin
                    chk($sformatf("rr_grant%0d", ngr), 64'(req_ready), 64'(4'(1) << (ngr % 4)));
                    if (ngr > 0) chk($sformatf("rr_interval%0d", ngr), 64'(cyc - last), 64'(LAT0 + 3));
                    last = cyc;
                    ngr++;
                end
                @(posedge clk); #1;
            end
            chk("rr_grant_count", 64'(ngr), 5);
            req_valid = '0;
        end

        // MUL_LAT=2: latency, held response under backpressure, reset while busy
        begin
            int n;
            int nresp;
            do_reset();
            v2 = 4'b0001; a2 = 32'h000000FF; b2 = 32'h000000FF; rr2 = 1'b0;
            @(negedge clk);
            chk("lat2_ready", 64'(rdy2), 1);
            @(posedge clk); #1 v2 = 4'b1111;
            n = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                n++;
                if (rv2) break;
                chk($sformatf("lat2_ready_busy%0d", c), 64'(rdy2), 0);
            end
            chk("lat2_latency", 64'(n), 64'(LAT2 + 2));
            for (int c = 0; c < 5; c++) begin
                chk($sformatf("hold%0d_valid", c), 64'(rv2), 1);
                chk($sformatf("hold%0d_p", c), 64'(rp2), 65025);
                chk($sformatf("hold%0d_id", c), 64'(rid2), 0);
                chk($sformatf("hold%0d_ready", c), 64'(rdy2), 0);
                @(negedge clk);
            end
            @(posedge clk); #1 rr2 = 1'b1;
            @(negedge clk);
            chk("release_ready_same", 64'(rdy2), 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("release_valid", 64'(rv2), 0);
            chk("release_grant", 64'(rdy2), 4'b0010);
            @(posedge clk); #1 rst = 1'b1;
            @(negedge clk);
            chk("prerst_busy", 64'(busy2), 1);
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            chk("postrst_valid", 64'(rv2), 0);
            chk("postrst_busy", 64'(busy2), 0);
            chk("postrst_ptr0", 64'(rdy2), 4'b0001);
            @(posedge clk); #1 v2 = '0;
            nresp = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (rv2) begin
                    nresp++;
                    chk("postrst_id", 64'(rid2), 0);
                    chk("postrst_p", 64'(rp2), 65025);
                end
                @(posedge clk); #1;
            end
            chk("postrst_resp_count", 64'(nresp), 1);
        end

        // random traffic vs. transaction-level model (u0, MUL_LAT=0)
        begin
            bit          outst = 0;
            int          acc = 0;
            int          ptr = 0;
            int          w;
            int          ops = 0;
            int          waitc = 0;
            logic [1:0]  eid = '0;
            logic [7:0]  ema = '0, emb = '0;
            logic [15:0] ep = '0;
            logic [3:0]  erdy;
            bit          ev;
            do_reset();
            for (int cyc = 0; cyc < 400; cyc++) begin
                req_valid = 4'($urandom_range(0, 15));
                req_a = $urandom;
                req_b = $urandom;
                resp_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                ev = outst && (cyc >= acc + LAT0 + 2);
                w = -1;
                if (!outst)
                    for (int k = 0; k < 4; k++)
                        if (w < 0 && req_valid[(ptr + k) % 4]) w = (ptr + k) % 4;
                erdy = (w >= 0) ? 4'(4'(1) << w) : 4'b0;
                chk("rnd_ready", 64'(req_ready), 64'(erdy));
                chk("rnd_busy", 64'(busy), 64'(outst));
                chk("rnd_valid", 64'(resp_valid), 64'(ev));
                chk("rnd_mul_a", 64'(mul_a), 64'(ema));
                chk("rnd_mul_b", 64'(mul_b), 64'(emb));
                if (ev) begin
                    chk("rnd_id", 64'(resp_id), 64'(eid));
                    chk("rnd_p", 64'(resp_p), 64'(ep));
                end
                if ((|req_valid) && erdy == 4'b0) waitc++;
                if (w >= 0) begin
                    outst = 1; acc = cyc; eid = 2'(w);
                    ema = req_a[w*8 +: 8]; emb = req_b[w*8 +: 8];
                    ep = 16'(ema) * 16'(emb);
                    ptr = (w + 1) % 4;
                end else if (ev && resp_ready) begin
                    outst = 0;
                    ops++;
                end
                @(posedge clk); #1;
            end
`ifdef OPTMULT_SCHED_STATS_EN
            chk("stat_ops", 64'(stat_ops), 64'(ops));
            chk("stat_wait", 64'(stat_wait), 64'(waitc));
`endif
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
